// File: rtl/ili9341_cmd_sequencer.sv
// ILI9341 command sequencer: LCD hardware-reset pulse, ROM-driven init walk,
// then runtime address-window sequences (0x2A/0x2B/0x2C).
// Optional build macro ILI9341_SEQ_DELAY_EN enables timed delay entries.
// Without it, delay entries are skipped in one cycle and no delay counter exists.
//
// Byte handshake: o_tx_valid rises with o_tx_data/o_tx_dc stable and holds
// them unchanged until a cycle where o_tx_valid & i_tx_ready is sampled high
// at posedge i_clk. That cycle is the transfer. o_tx_valid never drops
// before the transfer unless i_rst is asserted.
module ili9341_cmd_sequencer #(
   parameter int DEPTH        = 48,
   parameter int DELAY_W      = 16,
   parameter int TICKS_PER_MS = 100000,
   parameter int RST_LOW_CYC  = 1000,
   parameter int RST_WAIT_CYC = 12000000,
   parameter int H_RES        = 240,
   parameter int V_RES        = 320,
   localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_start,
   output logic          o_busy,
   output logic          o_init_done,
   output logic [AW-1:0] o_rom_addr,
   input  logic [9:0]    i_rom_data,
   input  logic          i_win_req,
   output logic          o_win_ack,
   input  logic [15:0]   i_win_x0,
   input  logic [15:0]   i_win_x1,
   input  logic [15:0]   i_win_y0,
   input  logic [15:0]   i_win_y1,
   output logic          o_tx_valid,
   input  logic          i_tx_ready,
   output logic [7:0]    o_tx_data,
   output logic          o_tx_dc,
   output logic          o_lcd_rst_n,
   output logic [3:0]    o_dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_HRST_LO   = 4'd1,
      S_HRST_WAIT = 4'd2,
      S_FETCH     = 4'd3,
      S_DECODE    = 4'd4,
      S_SEND      = 4'd5,
      S_DELAY     = 4'd6,
      S_READY     = 4'd7,
      S_WIN       = 4'd8
   } state_t;

   localparam int CNT_MAX_RST = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
`ifdef ILI9341_SEQ_DELAY_EN
   localparam int CNT_MAX = (TICKS_PER_MS > CNT_MAX_RST) ? TICKS_PER_MS : CNT_MAX_RST;
`else
   localparam int CNT_MAX = CNT_MAX_RST;
`endif
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] LO_LAST   = CNT_W'(RST_LOW_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
   localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [15:0]      X_LIM     = 16'(H_RES - 1);
   localparam logic [15:0]      Y_LIM     = 16'(V_RES - 1);

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [AW-1:0]    r_addr;
   logic [7:0]       r_tx_data;
   logic             r_tx_dc;
   logic             r_init_done;
   logic             r_win_ack;
   logic [3:0]       r_widx;
   logic [15:0]      r_x0, r_x1, r_y0, r_y1;

   logic             w_hs, w_last, w_cnt_done, w_counting;
   logic             w_addr_clr, w_addr_inc, w_load_byte, w_load_win, w_win_inc, w_ack;
   logic             w_load_ms, w_ms_dec;
   logic [7:0]       w_win_byte;
   logic             w_win_dc;
   logic [15:0]      w_xa, w_xb, w_ya, w_yb;

   function automatic logic [15:0] f_clamp(input logic [15:0] v, input logic [15:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   assign w_hs       = o_tx_valid & i_tx_ready;
   assign w_last     = (r_addr == LAST_ADDR);
   assign w_counting = (r_state == S_HRST_LO) || (r_state == S_HRST_WAIT) || (r_state == S_DELAY);

   // Window corners: order each pair low/high, then clamp to the panel size
   assign w_xa = f_clamp((i_win_x0 > i_win_x1) ? i_win_x1 : i_win_x0, X_LIM);
   assign w_xb = f_clamp((i_win_x0 > i_win_x1) ? i_win_x0 : i_win_x1, X_LIM);
   assign w_ya = f_clamp((i_win_y0 > i_win_y1) ? i_win_y1 : i_win_y0, Y_LIM);
   assign w_yb = f_clamp((i_win_y0 > i_win_y1) ? i_win_y0 : i_win_y1, Y_LIM);

`ifdef ILI9341_SEQ_DELAY_EN
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_MS - 1);
   logic [DELAY_W-1:0] r_ms;

   // Remaining delay units, loaded from the entry payload
   always_ff @(posedge i_clk) begin
      if (i_rst)          r_ms <= '0;
      else if (w_load_ms) r_ms <= DELAY_W'(i_rom_data[7:0]);
      else if (w_ms_dec)  r_ms <= r_ms - DELAY_W'(1);
   end
`else
   // Delay parameters stay referenced even though the delay path is compiled out
   logic w_unused_delay_cfg;
   assign w_unused_delay_cfg = (DELAY_W > 0) ^ (TICKS_PER_MS > 0);
`endif

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode and datapath strobes
   always_comb begin
      w_next      = r_state;
      w_cnt_done  = 1'b0;
      w_addr_clr  = 1'b0;
      w_addr_inc  = 1'b0;
      w_load_byte = 1'b0;
      w_load_win  = 1'b0;
      w_win_inc   = 1'b0;
      w_ack       = 1'b0;
      w_load_ms   = 1'b0;
      w_ms_dec    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_addr_clr = 1'b1;
               w_next     = S_HRST_LO;
            end
         end
         S_HRST_LO: begin
            w_cnt_done = (r_cnt == LO_LAST);
            if (w_cnt_done) w_next = S_HRST_WAIT;
         end
         S_HRST_WAIT: begin
            w_cnt_done = (r_cnt == WAIT_LAST);
            if (w_cnt_done) w_next = S_FETCH;
         end
         S_FETCH: w_next = S_DECODE;
         S_DECODE: begin
            if (!i_rom_data[9]) begin
               w_load_byte = 1'b1;
               w_next      = S_SEND;
            end else if (i_rom_data[7:0] == 8'd0) begin
               w_next = S_READY;
            end else begin
`ifdef ILI9341_SEQ_DELAY_EN
               w_load_ms = 1'b1;
               w_next    = S_DELAY;
`else
               if (w_last) begin
                  w_next = S_READY;
               end else begin
                  w_addr_inc = 1'b1;
                  w_next     = S_FETCH;
               end
`endif
            end
         end
         S_SEND: begin
            if (w_hs) begin
               if (w_last) begin
                  w_next = S_READY;
               end else begin
                  w_addr_inc = 1'b1;
                  w_next     = S_FETCH;
               end
            end
         end
`ifdef ILI9341_SEQ_DELAY_EN
         S_DELAY: begin
            w_cnt_done = (r_cnt == TICK_LAST);
            if (w_cnt_done) begin
               if (r_ms == DELAY_W'(1)) begin
                  if (w_last) begin
                     w_next = S_READY;
                  end else begin
                     w_addr_inc = 1'b1;
                     w_next     = S_FETCH;
                  end
               end else begin
                  w_ms_dec = 1'b1;
               end
            end
         end
`endif
         S_READY: begin
            if (i_start) begin
               w_addr_clr = 1'b1;
               w_next     = S_HRST_LO;
            end else if (i_win_req) begin
               w_load_win = 1'b1;
               w_next     = S_WIN;
            end
         end
         S_WIN: begin
            if (w_hs) begin
               if (r_widx == 4'd10) begin
                  w_ack  = 1'b1;
                  w_next = S_READY;
               end else begin
                  w_win_inc = 1'b1;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Window byte selector: command, then big-endian start/end coordinates
   always_comb begin
      w_win_byte = 8'h00;
      w_win_dc   = 1'b1;
      case (r_widx)
         4'd0:    begin w_win_byte = 8'h2A; w_win_dc = 1'b0; end
         4'd1:    w_win_byte = r_x0[15:8];
         4'd2:    w_win_byte = r_x0[7:0];
         4'd3:    w_win_byte = r_x1[15:8];
         4'd4:    w_win_byte = r_x1[7:0];
         4'd5:    begin w_win_byte = 8'h2B; w_win_dc = 1'b0; end
         4'd6:    w_win_byte = r_y0[15:8];
         4'd7:    w_win_byte = r_y0[7:0];
         4'd8:    w_win_byte = r_y1[15:8];
         4'd9:    w_win_byte = r_y1[7:0];
         4'd10:   begin w_win_byte = 8'h2C; w_win_dc = 1'b0; end
         default: begin w_win_byte = 8'h00; w_win_dc = 1'b0; end
      endcase
   end

   // Datapath: counters, ROM address, byte latch, window coordinates, flags
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_addr      <= '0;
         r_tx_data   <= 8'h00;
         r_tx_dc     <= 1'b0;
         r_init_done <= 1'b0;
         r_win_ack   <= 1'b0;
         r_widx      <= 4'd0;
         r_x0        <= 16'd0;
         r_x1        <= 16'd0;
         r_y0        <= 16'd0;
         r_y1        <= 16'd0;
      end else begin
         r_win_ack <= w_ack;
         if (w_cnt_done || (w_next != r_state)) r_cnt <= '0;
         else if (w_counting)                   r_cnt <= r_cnt + CNT_W'(1);
         if (w_addr_clr)      r_addr <= '0;
         else if (w_addr_inc) r_addr <= r_addr + AW'(1);
         if (w_load_byte) begin
            r_tx_data <= i_rom_data[7:0];
            r_tx_dc   <= i_rom_data[8];
         end
         if (w_load_win) begin
            r_x0   <= w_xa;
            r_x1   <= w_xb;
            r_y0   <= w_ya;
            r_y1   <= w_yb;
            r_widx <= 4'd0;
         end else if (w_win_inc) begin
            r_widx <= r_widx + 4'd1;
         end
         if (w_addr_clr)              r_init_done <= 1'b0;
         else if (w_next == S_READY)  r_init_done <= 1'b1;
      end
   end

   assign o_tx_valid  = (r_state == S_SEND) || (r_state == S_WIN);
   assign o_tx_data   = (r_state == S_WIN) ? w_win_byte : r_tx_data;
   assign o_tx_dc     = (r_state == S_WIN) ? w_win_dc : r_tx_dc;
   assign o_lcd_rst_n = (r_state != S_HRST_LO);
   assign o_busy      = (r_state != S_IDLE) && (r_state != S_READY);
   assign o_init_done = r_init_done;
   assign o_rom_addr  = r_addr;
   assign o_win_ack   = r_win_ack;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ili9341_cmd_sequencer.sv
// Bench for ili9341_cmd_sequencer: registered ROM model, byte scoreboard,
// hardware-reset timing, delay/skip gaps, window swap/clamp and retrigger.
module tb_ili9341_cmd_sequencer;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_FETCH = 4'd3;
   localparam logic [3:0] S_SEND  = 4'd5;
   localparam logic [3:0] S_DELAY = 4'd6;
   localparam logic [3:0] S_READY = 4'd7;
`ifdef ILI9341_SEQ_DELAY_EN
   localparam int EXP_DLY = 20;
   localparam int EXP_GAP = 25;
`else
   localparam int EXP_DLY = 0;
   localparam int EXP_GAP = 5;
`endif

   logic          clk, rst, start, busy, init_done, win_req, win_ack;
   logic [AW-1:0] rom_addr;
   logic [9:0]    rom_q;
   logic [15:0]   x0, x1, y0, y1;
   logic          tx_valid, tx_ready, tx_dc, lcd_rst_n;
   logic [7:0]    tx_data;
   logic [3:0]    dbg_state;
   logic [9:0]    rom [DEPTH];

   int            n_checks, n_errors, cyc, dly_cyc, ack_cnt;
   logic [8:0]    exp_q[$];
   int            hs_t[$];

   ili9341_cmd_sequencer #(
      .DEPTH(DEPTH), .DELAY_W(8), .TICKS_PER_MS(10), .RST_LOW_CYC(4),
      .RST_WAIT_CYC(8), .H_RES(240), .V_RES(320)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy),
      .o_init_done(init_done), .o_rom_addr(rom_addr), .i_rom_data(rom_q),
      .i_win_req(win_req), .o_win_ack(win_ack), .i_win_x0(x0), .i_win_x1(x1),
      .i_win_y0(y0), .i_win_y1(y1), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
      .o_tx_data(tx_data), .o_tx_dc(tx_dc), .o_lcd_rst_n(lcd_rst_n),
      .o_dbg_state(dbg_state)
   );

   // Clock and ROM with one-cycle read latency
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) rom_q <= rom[rom_addr];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Scoreboard monitor: transfers pop the queue, stalls must hold the head value
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (win_ack) ack_cnt++;
         if (dbg_state == S_DELAY) dly_cyc++;
         if (tx_valid) begin
            if (exp_q.size() == 0)
               check_eq("byte_without_expectation", exp_q.size(), 1);
            else if (tx_ready) begin
               check_eq("tx_byte", {23'd0, tx_dc, tx_data}, {23'd0, exp_q.pop_front()});
               hs_t.push_back(cyc);
            end else
               check_eq("tx_stall_hold", {23'd0, tx_dc, tx_data}, {23'd0, exp_q[0]});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic push_byte(input logic dc, input logic [7:0] d);
      exp_q.push_back({dc, d});
   endtask

   task automatic push_win(input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] b0, input logic [15:0] b1);
      logic [15:0] xl, xh, yl, yh;
      xl = (a0 < a1) ? a0 : a1;  xh = (a0 < a1) ? a1 : a0;
      yl = (b0 < b1) ? b0 : b1;  yh = (b0 < b1) ? b1 : b0;
      if (xl > 16'd239) xl = 16'd239;
      if (xh > 16'd239) xh = 16'd239;
      if (yl > 16'd319) yl = 16'd319;
      if (yh > 16'd319) yh = 16'd319;
      push_byte(1'b0, 8'h2A);
      push_byte(1'b1, xl[15:8]); push_byte(1'b1, xl[7:0]);
      push_byte(1'b1, xh[15:8]); push_byte(1'b1, xh[7:0]);
      push_byte(1'b0, 8'h2B);
      push_byte(1'b1, yl[15:8]); push_byte(1'b1, yl[7:0]);
      push_byte(1'b1, yh[15:8]); push_byte(1'b1, yh[7:0]);
      push_byte(1'b0, 8'h2C);
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
      int k;
      logic found;
      k = 0;
      found = 1'b0;
      while (!found && k < budget) begin
         @(negedge clk);
         k++;
         if (dbg_state == s) found = 1'b1;
      end
      check_eq(tag, {31'd0, found}, 32'd1);
   endtask

   task automatic wait_acks(input int n_acks, input int budget, input string tag);
      int k, seen;
      k = 0;
      seen = 0;
      while (seen < n_acks && k < budget) begin
         @(negedge clk);
         k++;
         if (win_ack) seen++;
      end
      win_req = 1'b0;
      check_eq(tag, seen, n_acks);
   endtask

   task automatic load_rom_a();
      for (int i = 0; i < DEPTH; i++) rom[i] = 10'h200;
      rom[0] = 10'h0CB;
      rom[1] = 10'h139;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      int lo, hi;
      n_checks = 0; n_errors = 0; cyc = 0; dly_cyc = 0; ack_cnt = 0;
      rst = 1'b1; start = 1'b0; win_req = 1'b0; tx_ready = 1'b1;
      x0 = 16'd0; x1 = 16'd0; y0 = 16'd0; y1 = 16'd0;
      load_rom_a();
      tick(3);
      rst = 1'b0;
      tick(1);

      // Reset values
      @(negedge clk);
      check_eq("rst_tx_valid", tx_valid, 0);
      check_eq("rst_tx_data", tx_data, 0);
      check_eq("rst_tx_dc", tx_dc, 0);
      check_eq("rst_lcd_rst_n", lcd_rst_n, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_init_done", init_done, 0);
      check_eq("rst_rom_addr", rom_addr, 0);
      check_eq("rst_win_ack", win_ack, 0);
      check_eq("rst_state", dbg_state, S_IDLE);

      // Hardware-reset timing and init table
      tick(1);
      hs_t.delete();
      push_byte(1'b0, 8'hCB);
      push_byte(1'b1, 8'h39);
      pulse_start();
      @(negedge clk);
      lo = 0;
      while (lcd_rst_n === 1'b1 && lo < 50) begin @(negedge clk); lo++; end
      check_eq("busy_in_hw_reset", busy, 1);
      lo = 0;
      while (lcd_rst_n === 1'b0 && lo < 50) begin lo++; @(negedge clk); end
      check_eq("lcd_rst_low_cycles", lo, 4);
      hi = 0;
      while (dbg_state != S_FETCH && hi < 50) begin hi++; @(negedge clk); end
      check_eq("lcd_rst_wait_cycles", hi, 8);
      check_eq("first_fetch_addr", rom_addr, 0);
      wait_state(S_READY, 100, "init_reach_ready");
      check_eq("init_done_set", init_done, 1);
      check_eq("busy_ready", busy, 0);
      check_eq("init_handshakes", hs_t.size(), 2);
      if (hs_t.size() == 2) check_eq("init_byte_spacing", hs_t[1] - hs_t[0], 3);

      // Backpressure on 0x11, then a 2-unit delay entry
      tick(1);
      rom[0] = 10'h011; rom[1] = 10'h202; rom[2] = 10'h122; rom[3] = 10'h200;
      hs_t.delete();
      dly_cyc = 0;
      tx_ready = 1'b0;
      push_byte(1'b0, 8'h11);
      push_byte(1'b1, 8'h22);
      pulse_start();
      wait_state(S_SEND, 100, "stall_reach_send");
      repeat (5) @(negedge clk);
      @(posedge clk); #1;
      tx_ready = 1'b1;
      wait_state(S_READY, 200, "delay_reach_ready");
      check_eq("delay_cycles", dly_cyc, EXP_DLY);
      check_eq("delay_handshakes", hs_t.size(), 2);
      if (hs_t.size() == 2) check_eq("delay_gap", hs_t[1] - hs_t[0], EXP_GAP);

      // Window with swap and clamp
      tick(1);
      hs_t.delete();
      ack_cnt = 0;
      x0 = 16'd300; x1 = 16'd10; y0 = 16'd0; y1 = 16'd400;
      push_win(x0, x1, y0, y1);
      win_req = 1'b1;
      wait_acks(1, 100, "win_ack_seen");
      tick(3);
      check_eq("win_ack_width", ack_cnt, 1);
      check_eq("win_back_ready", dbg_state, S_READY);
      check_eq("win_bytes", hs_t.size(), 11);
      if (hs_t.size() == 11) check_eq("win_back_to_back", hs_t[10] - hs_t[0], 10);

      // Held request retriggers a second sequence
      x0 = 16'd5; x1 = 16'h1234; y0 = 16'd7; y1 = 16'd7;
      push_win(x0, x1, y0, y1);
      push_win(x0, x1, y0, y1);
      win_req = 1'b1;
      wait_acks(2, 200, "win_retrigger_acks");
      tick(3);
      check_eq("retrigger_drained", exp_q.size(), 0);
      check_eq("retrigger_idle", dbg_state, S_READY);

      // Full table with no end marker stops at the last entry
      for (int i = 0; i < DEPTH; i++) begin
         rom[i] = {1'b0, i[0], 8'h40 + 8'(i)};
         push_byte(i[0], 8'h40 + 8'(i));
      end
      pulse_start();
      wait_state(S_READY, 300, "full_reach_ready");
      check_eq("full_last_addr", rom_addr, DEPTH - 1);
      check_eq("full_drained", exp_q.size(), 0);

      // Window request raised during init waits for READY
      tick(1);
      load_rom_a();
      hs_t.delete();
      push_byte(1'b0, 8'hCB);
      push_byte(1'b1, 8'h39);
      x0 = 16'h0010; x1 = 16'h0020; y0 = 16'h0030; y1 = 16'h0040;
      push_win(x0, x1, y0, y1);
      pulse_start();
      tick(2);
      win_req = 1'b1;
      wait_acks(1, 400, "early_req_ack");
      check_eq("early_req_bytes", hs_t.size(), 13);
      if (hs_t.size() == 13) check_eq("early_req_gap", hs_t[2] - hs_t[1], 4);

      // Reset while a byte is stalled
      tick(2);
      tx_ready = 1'b0;
      push_byte(1'b0, 8'hCB);
      pulse_start();
      wait_state(S_SEND, 100, "midsend_reach_send");
      tick(1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq("midsend_tx_valid", tx_valid, 0);
      check_eq("midsend_state", dbg_state, S_IDLE);
      check_eq("midsend_init_done", init_done, 0);
      exp_q.delete();
      tick(1);
      rst = 1'b0;
      tx_ready = 1'b1;
      hs_t.delete();
      push_byte(1'b0, 8'hCB);
      push_byte(1'b1, 8'h39);
      pulse_start();
      wait_state(S_READY, 100, "replay_reach_ready");
      check_eq("replay_handshakes", hs_t.size(), 2);

      check_eq("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ili9341_cmd_sequencer.md
Name: ili9341_cmd_sequencer

Overview:
- Parametrised successor to the fixed ILI9341 init-command table.
- Walks an external command ROM of DEPTH entries after issuing an LCD hardware-reset pulse, and presents each byte with its D/C flag to the SPI byte transmitter over a valid/ready handshake.
- Supports timed delay entries and an end marker.
- After init, runs the address-window loop sequence (0x2A/0x2B/0x2C) on request with runtime coordinates.

Parameters:
- DEPTH, 48, number of ROM entries.
- DELAY_W, 16, width of the delay-tick counter.
- TICKS_PER_MS, 100000, clk cycles per delay unit (1 ms).
- RST_LOW_CYC, 1000, cycles lcd_rst_n is held low.
- RST_WAIT_CYC, 12000000, cycles waited after lcd_rst_n rises, before the first fetch.
- H_RES, 240, horizontal resolution (clamp limit).
- V_RES, 320, vertical resolution (clamp limit).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins hardware reset plus init
- busy  out  1  high from the accepted start until READY, and during window sequences
- init_done  out  1  set on reaching READY; held until rst or the next start
- rom_addr  out  $clog2(DEPTH)  ROM read address; ROM has 1-cycle read latency
- rom_data  in  10  entry: [9]=special, [8]=dc, [7:0]=payload
- win_req  in  1  level request for a window update
- win_ack  out  1  1-cycle pulse when the 0x2C byte is accepted
- win_x0, win_x1, win_y0, win_y1  in  16  window coordinates, sampled at win_req acceptance
- tx_valid  out  1  byte available to the SPI transmitter
- tx_ready  in  1  transmitter accepts the byte when tx_valid & tx_ready
- tx_data  out  8  byte to send
- tx_dc  out  1  0 = command, 1 = data
- lcd_rst_n  out  1  LCD hardware reset, active low

Behaviour:
- Reset values: tx_valid=0, tx_data=0, tx_dc=0, lcd_rst_n=1, busy=0, init_done=0, rom_addr=0, win_ack=0. State=IDLE. All counters cleared.
- Reset mid-operation aborts any sequence at once. tx_valid drops in the same cycle rst is sampled.
- States and transitions:
  - IDLE: waits for start.
  - HRST_LO: lcd_rst_n=0 for RST_LOW_CYC cycles.
  - HRST_WAIT: lcd_rst_n=1 for RST_WAIT_CYC cycles.
  - FETCH: drives rom_addr, waits 1 cycle.
  - DECODE: acts on rom_data.
  - SEND: tx_valid=1 until the handshake completes.
  - DELAY: counts out the delay.
  - READY: initialised and idle.
  - WIN: sends the window sequence.
- A start accepted in IDLE or READY clears init_done and rom_addr, then enters HRST_LO. start in any other state is ignored.
- DECODE, by entry type:
  - special=0: tx_data=payload, tx_dc=dc; go to SEND.
  - special=1 with payload=0: end marker; go to READY.
  - special=1 with payload=N>0: go to DELAY for N*TICKS_PER_MS cycles, then increment rom_addr and return to FETCH.
- SEND: tx_data and tx_dc are held stable while tx_valid=1 and tx_ready=0. On the handshake, tx_valid falls next cycle and rom_addr increments. After entry DEPTH-1 the block enters READY even with no end marker (no wrap).
- Throughput: one byte per 3 cycles minimum (FETCH, DECODE, SEND) with tx_ready tied high.
- READY: busy=0, init_done=1. win_req is accepted only here; a win_req raised before READY waits, unacknowledged, until READY.
- Window acceptance:
  - Coordinates are latched.
  - If x0>x1 the pair is swapped; likewise y.
  - Each x value is clamped to H_RES-1; each y value to V_RES-1.
- WIN sends 11 bytes, one per handshake, no idle gap required:
  - 0x2A(dc0), x0[15:8], x0[7:0], x1[15:8], x1[7:0](dc1)
  - 0x2B(dc0), y0 hi/lo, y1 hi/lo(dc1)
  - 0x2C(dc0)
- win_ack pulses in the cycle after 0x2C is accepted; the block returns to READY.
- win_req held high re-triggers a further window sequence.

Optional Feature:
- Macro ILI9341_SEQ_DELAY_EN.
- Defined: delay entries behave as above.
- Undefined: special=1 entries with nonzero payload are skipped in 1 cycle (no wait, no byte sent); the DELAY state and the DELAY_W counter are not synthesised.

Test Plan:
- Reset/hardware-reset timing: rst, then start with RST_LOW_CYC=4 and RST_WAIT_CYC=8 -> lcd_rst_n low for exactly 4 cycles, high 8 cycles before the first rom_addr=0 fetch; all outputs at reset values before start.
- Init table: ROM {0,0,CB},{0,1,39},{1,0,00}, tx_ready=1 -> bytes CB(dc0), 39(dc1), then READY; init_done=1, busy=0; exactly 2 handshakes.
- Backpressure and delay: tx_ready low for 5 cycles on byte 0x11, then entry {1,0,02} with TICKS_PER_MS=10 -> tx_data/tx_dc stable while stalled; 20-cycle gap before the next fetch (macro defined), no gap (macro undefined).
- Window with swap and clamp: win_req with x0=300, x1=10, y0=0, y1=400 -> 2A, 00, 0A, 00, EF, 2B, 00, 00, 01, 3F, 2C; win_ack is a single pulse.
- Early request: win_req asserted during init -> no tx bytes interleaved with init; window sequence starts right after READY.
- Reset mid-SEND: rst asserted while tx_valid=1 and tx_ready=0 -> tx_valid=0 next cycle; state IDLE; a new start replays from rom_addr=0.
